// File: rtl/router_pkg.sv
// Shared definitions for the XY mesh router: port count, port indices and
// the dimension-ordered route function.
package router_pkg;

  localparam int NUM_PORTS  = 5;
  localparam int PORT_IDX_W = 3;

  typedef enum logic [PORT_IDX_W-1:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } port_e;

  // X is resolved first, then Y; a flit addressed to this node goes LOCAL.
  // Coordinates are passed zero-extended to 8 bits so any field width fits.
  function automatic port_e xy_route(input logic [7:0] dst_x,
                                     input logic [7:0] dst_y,
                                     input logic [7:0] src_x,
                                     input logic [7:0] src_y);
    if (dst_x > src_x)      return PORT_EAST;
    else if (dst_x < src_x) return PORT_WEST;
    else if (dst_y > src_y) return PORT_NORTH;
    else if (dst_y < src_y) return PORT_SOUTH;
    else                    return PORT_LOCAL;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Input flit FIFO with valid/ready on both sides. The head is presented
// combinationally so a flit written at one edge can be granted at the next.
module flit_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic                  full;
  logic                  empty;
  logic                  push_fire;
  logic                  pop_fire;

  // The extra pointer MSB distinguishes full (MSBs differ) from empty.
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push_ready = ~full & rst;
  assign push_fire  = push_valid & push_ready;
  assign pop_valid  = ~empty;
  assign pop_fire   = pop_ready & ~empty;
  assign pop_data   = mem[rd_ptr_reg[AW-1:0]];

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Read and write pointers; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/xy_mesh_router.sv
// Five-port XY mesh router for single-flit packets. Each enabled input has a
// FIFO; heads are routed X-then-Y, arbitrated round-robin per output and held
// in a one-entry output register. Flits routed to a disabled port are dropped
// and counted in a saturating counter.
module xy_mesh_router
  import router_pkg::*;
#(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   X_BITS     = 2,
  parameter int                   Y_BITS     = 2,
  parameter int                   SRC_X      = 0,
  parameter int                   SRC_Y      = 0,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [NUM_PORTS-1:0] PORT_EN    = 5'b11111
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]            out_valid,
  input  logic [NUM_PORTS-1:0]            out_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  output logic [7:0]                      drop_count
);

  logic [NUM_PORTS-1:0]                       head_valid;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]       head_data;
  logic [NUM_PORTS-1:0][PORT_IDX_W-1:0]       head_route;
  logic [NUM_PORTS-1:0]                       drop;
  logic [NUM_PORTS-1:0]                       pop;
  // grant[o][i]: output o takes the head of input i this cycle.
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]        grant;
  logic [2:0]                                 drop_sum;
  logic [8:0]                                 drop_total;
  logic [7:0]                                 drop_count_reg;

  // ------------------------------------------------------------------
  // Input side: one FIFO per enabled port plus route computation.
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
    if (PORT_EN[gi]) begin : g_on
      logic  push_ready;
      port_e route;

      flit_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_valid(in_valid[gi]),
        .push_ready(push_ready),
        .push_data (in_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .pop_valid (head_valid[gi]),
        .pop_ready (pop[gi]),
        .pop_data  (head_data[gi])
      );

      assign route = xy_route(8'(head_data[gi][DATA_WIDTH-1 -: X_BITS]),
                              8'(head_data[gi][DATA_WIDTH-1-X_BITS -: Y_BITS]),
                              8'(SRC_X), 8'(SRC_Y));
      assign in_ready[gi]   = push_ready;
      assign head_route[gi] = route;
    end else begin : g_off
      assign in_ready[gi]   = 1'b0;
      assign head_valid[gi] = 1'b0;
      assign head_data[gi]  = '0;
      assign head_route[gi] = PORT_LOCAL;
    end

    logic granted_any;

    // A head leaves its FIFO when any output grants it or it is dropped.
    always_comb begin
      granted_any = 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) granted_any = granted_any | grant[o][gi];
    end

    assign drop[gi] = head_valid[gi] & ~PORT_EN[head_route[gi]];
    assign pop[gi]  = drop[gi] | granted_any;
  end

  // ------------------------------------------------------------------
  // Output side: round-robin arbiter and one-entry register per port.
  // ------------------------------------------------------------------
  for (genvar go = 0; go < NUM_PORTS; go++) begin : g_out
    if (PORT_EN[go]) begin : g_on
      logic [NUM_PORTS-1:0]  req;
      logic [NUM_PORTS-1:0]  gnt;
      logic [2:0]            rr_ptr_reg;
      logic [2:0]            win;
      logic [3:0]            idx;
      logic                  found;
      logic                  can_load;
      logic                  out_valid_reg;
      logic [DATA_WIDTH-1:0] out_data_reg;

      // Collect heads whose route targets this output.
      always_comb begin
        req = '0;
        for (int i = 0; i < NUM_PORTS; i++)
          req[i] = head_valid[i] & ~drop[i] & (head_route[i] == 3'(go));
      end

      assign can_load = ~out_valid_reg | out_ready[go];

      // Pick the first requester at or after the pointer, wrapping mod 5.
      always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx = 4'(rr_ptr_reg) + 4'(k);
          if (idx >= 4'(NUM_PORTS)) idx = idx - 4'(NUM_PORTS);
          if (!found && can_load && req[idx[2:0]]) begin
            gnt[idx[2:0]] = 1'b1;
            win           = idx[2:0];
            found         = 1'b1;
          end
        end
      end

      assign grant[go] = gnt;

      // Load on grant, clear on drain, otherwise hold; pointer moves only on grant.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          out_valid_reg <= 1'b0;
          out_data_reg  <= '0;
          rr_ptr_reg    <= '0;
        end else if (found) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= head_data[win];
          rr_ptr_reg    <= (win == 3'(NUM_PORTS-1)) ? 3'd0 : win + 3'd1;
        end else if (out_ready[go]) begin
          out_valid_reg <= 1'b0;
        end
      end

      assign out_valid[go]                          = out_valid_reg;
      assign out_data[go*DATA_WIDTH +: DATA_WIDTH]  = out_data_reg;
    end else begin : g_off
      assign grant[go]                              = '0;
      assign out_valid[go]                          = 1'b0;
      assign out_data[go*DATA_WIDTH +: DATA_WIDTH]  = '0;
    end
  end

  // ------------------------------------------------------------------
  // Drop counter: all drops of a cycle are summed, then saturated at 255.
  // ------------------------------------------------------------------
  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < NUM_PORTS; i++) drop_sum = drop_sum + 3'(drop[i]);
  end

  assign drop_total = {1'b0, drop_count_reg} + 9'(drop_sum);

  // Saturating accumulation of dropped flits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                drop_count_reg <= '0;
    else if (drop_total[8])  drop_count_reg <= 8'hFF;
    else                     drop_count_reg <= drop_total[7:0];
  end

  assign drop_count = drop_count_reg;

endmodule
